// File: rtl/mem_access_seq_if.sv
// Signal bundle between the instruction sequencer, the access sequencer and the SRAM pins.
// The sequencer side (master) drives strobes, address, write data, switches and SRAM read data.
interface mem_access_seq_if;
   logic        Mem_CE;
   logic        Mem_OE;
   logic        Mem_WE;
   logic [15:0] MAR;
   logic [15:0] MDR_wdata;
   logic [15:0] Switches;
   logic [15:0] SRAM_rdata;
   logic [19:0] SRAM_ADDR;
   logic        SRAM_CE_N;
   logic        SRAM_OE_N;
   logic        SRAM_WE_N;
   logic        SRAM_UB_N;
   logic        SRAM_LB_N;
   logic [15:0] SRAM_wdata;
   logic        SRAM_drive;
   logic [15:0] Rd_data;
   logic        Rd_valid;
   logic        Wr_done;
   logic [15:0] Hex_out;
   logic        Busy;
   logic        Err;

   modport slave (
      input  Mem_CE, Mem_OE, Mem_WE, MAR, MDR_wdata, Switches, SRAM_rdata,
      output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
      output SRAM_wdata, SRAM_drive, Rd_data, Rd_valid, Wr_done, Hex_out, Busy, Err
   );

   modport master (
      output Mem_CE, Mem_OE, Mem_WE, MAR, MDR_wdata, Switches, SRAM_rdata,
      input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
      input  SRAM_wdata, SRAM_drive, Rd_data, Rd_valid, Wr_done, Hex_out, Busy, Err
   );
endinterface

// File: rtl/mem_access_seq.sv
// Turns the sequencer's active-low Mem_* strobes into timed SRAM read/write cycles,
// with address 16'hFFFF mapped to the switch input (read) and hex register (write).
module mem_access_seq #(
   parameter int WAIT_CYCLES = 0
) (
   input logic              Clk,
   input logic              Reset_n,
   mem_access_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, RD_ACC, RD_CAP, RD_HOLD, WR_SETUP, WR_PULSE, WR_REC, WR_HOLD
   } state_t;

   localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_CYCLES);
   localparam logic [15:0] IO_ADDR   = 16'hFFFF;

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_count;
   logic [2:0]  w_countNext;
   logic [19:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_rdData;
   logic [15:0] r_hex;
   logic        r_isIo;
   logic        r_rdValid;
   logic        r_wrDone;
   logic        r_err;
   logic        w_rdReq;
   logic        w_wrReq;
   logic        w_conflict;
   logic        w_loadAddr;
   logic        w_ce;
   logic        w_oe;
   logic        w_we;
   logic        w_drive;

   // A write request takes priority whenever Mem_WE is low, even if Mem_OE is also low.
   assign w_wrReq    = !bus.Mem_CE && !bus.Mem_WE;
   assign w_rdReq    = !bus.Mem_CE && !bus.Mem_OE && bus.Mem_WE;
   assign w_conflict = w_wrReq && !bus.Mem_OE;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
         r_count <= 3'd0;
      end else begin
         r_state <= w_next;
         r_count <= w_countNext;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_countNext = r_count;
      w_loadAddr  = 1'b0;
      w_ce        = 1'b0;
      w_oe        = 1'b0;
      w_we        = 1'b0;
      w_drive     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_wrReq) begin
               w_next     = WR_SETUP;
               w_loadAddr = 1'b1;
            end else if (w_rdReq) begin
               w_next      = RD_ACC;
               w_loadAddr  = 1'b1;
               w_countNext = WAIT_LOAD;
            end
         end
         RD_ACC: begin
            w_ce = 1'b1;
            w_oe = 1'b1;
            if (r_count == 3'd0) w_next = RD_CAP;
            else                 w_countNext = r_count - 3'd1;
         end
         RD_CAP: begin
            w_ce   = 1'b1;
            w_oe   = 1'b1;
            w_next = RD_HOLD;
         end
         RD_HOLD: begin
            if (bus.Mem_OE) w_next = IDLE;
         end
         WR_SETUP: begin
            w_ce        = 1'b1;
            w_drive     = 1'b1;
            w_next      = WR_PULSE;
            w_countNext = WAIT_LOAD;
         end
         WR_PULSE: begin
            w_ce    = 1'b1;
            w_we    = 1'b1;
            w_drive = 1'b1;
            if (r_count == 3'd0) w_next = WR_REC;
            else                 w_countNext = r_count - 3'd1;
         end
         WR_REC: begin
            w_ce    = 1'b1;
            w_drive = 1'b1;
            w_next  = WR_HOLD;
         end
         WR_HOLD: begin
            if (bus.Mem_WE) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Address and write data are captured once at the start of an access so they stay frozen through the pulse.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_addr    <= 20'h0;
         r_wdata   <= 16'h0;
         r_rdData  <= 16'h0;
         r_hex     <= 16'h0;
         r_isIo    <= 1'b0;
         r_rdValid <= 1'b0;
         r_wrDone  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_rdValid <= (r_state == RD_CAP);
         r_wrDone  <= (r_state == WR_REC);
         if (w_loadAddr) begin
            r_addr <= {4'h0, bus.MAR};
            r_isIo <= (bus.MAR == IO_ADDR);
            if (w_wrReq) r_wdata <= bus.MDR_wdata;
         end
         if (r_state == RD_CAP) r_rdData <= r_isIo ? bus.Switches : bus.SRAM_rdata;
         if ((r_state == WR_REC) && r_isIo) r_hex <= r_wdata;
         if ((r_state == IDLE) && w_conflict) r_err <= 1'b1;
      end
   end

   // Strobes decode straight from state so an asynchronous reset releases them without waiting for an edge.
   assign bus.SRAM_CE_N  = !(w_ce && !r_isIo);
   assign bus.SRAM_OE_N  = !(w_oe && !r_isIo);
   assign bus.SRAM_WE_N  = !(w_we && !r_isIo);
   assign bus.SRAM_UB_N  = bus.SRAM_CE_N;
   assign bus.SRAM_LB_N  = bus.SRAM_CE_N;
   assign bus.SRAM_drive = w_drive && !r_isIo;
   assign bus.SRAM_ADDR  = r_addr;
   assign bus.SRAM_wdata = r_wdata;
   assign bus.Rd_data    = r_rdData;
   assign bus.Rd_valid   = r_rdValid;
   assign bus.Wr_done    = r_wrDone;
   assign bus.Hex_out    = r_hex;
   assign bus.Busy       = (r_state != IDLE);
   assign bus.Err        = r_err;

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: one instance with WAIT_CYCLES=0, one with WAIT_CYCLES=2,
// each with a small behavioural SRAM; read results go through an expected-data queue.
module tb_mem_access_seq;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          checkCount = 0;
   int          passCount  = 0;
   logic [15:0] rdExpQ[$];
   logic [15:0] mem0 [0:255];
   logic [15:0] mem2 [0:255];
   logic [4:0]  viol;

   always #5 clk = ~clk;

   mem_access_seq_if bus0();
   mem_access_seq_if bus2();

   mem_access_seq #(.WAIT_CYCLES(0)) dut0 (.Clk(clk), .Reset_n(rst_n), .bus(bus0.slave));
   mem_access_seq #(.WAIT_CYCLES(2)) dut2 (.Clk(clk), .Reset_n(rst_n), .bus(bus2.slave));

   assign bus0.SRAM_rdata = (!bus0.SRAM_CE_N && !bus0.SRAM_OE_N) ? mem0[bus0.SRAM_ADDR[7:0]] : 16'hDEAD;
   assign bus2.SRAM_rdata = (!bus2.SRAM_CE_N && !bus2.SRAM_OE_N) ? mem2[bus2.SRAM_ADDR[7:0]] : 16'hDEAD;

   // SRAM models sample mid-cycle, away from the edges where the strobes change.
   always @(negedge clk) begin
      if (!bus0.SRAM_CE_N && !bus0.SRAM_WE_N) mem0[bus0.SRAM_ADDR[7:0]] = bus0.SRAM_wdata;
      if (!bus2.SRAM_CE_N && !bus2.SRAM_WE_N) mem2[bus2.SRAM_ADDR[7:0]] = bus2.SRAM_wdata;
   end

   // Every-cycle rules plus the read scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         viol = {!bus0.SRAM_OE_N && !bus0.SRAM_WE_N,
                 !bus2.SRAM_OE_N && !bus2.SRAM_WE_N,
                 (bus0.SRAM_UB_N !== bus0.SRAM_CE_N) || (bus0.SRAM_LB_N !== bus0.SRAM_CE_N),
                 (bus2.SRAM_UB_N !== bus2.SRAM_CE_N) || (bus2.SRAM_LB_N !== bus2.SRAM_CE_N),
                 bus2.Rd_valid === 1'b1};
         checkCount++;
         if (viol !== 5'b0) $display("[TB] FAIL cycle_rules got=%b exp=%b at %0t", viol, 5'b0, $time);
         else passCount++;
         if (bus0.Rd_valid === 1'b1) begin
            checkCount++;
            if (rdExpQ.size() == 0) begin
               $display("[TB] FAIL rd_unexpected got Rd_data=%h with no read outstanding", bus0.Rd_data);
            end else begin
               logic [15:0] exp;
               exp = rdExpQ.pop_front();
               if (bus0.Rd_data !== exp) $display("[TB] FAIL rd_data got=%h exp=%h", bus0.Rd_data, exp);
               else passCount++;
            end
         end
      end
   end

   task automatic doRead0(input logic [15:0] addr, input logic [15:0] exp, input int nCyc,
                          output int oeLow, output int ceLow, output int validCyc,
                          output logic [19:0] addrSeen);
      oeLow = 0; ceLow = 0; validCyc = -1; addrSeen = '0;
      @(posedge clk); #1;
      bus0.MAR = addr; bus0.Mem_CE = 1'b0; bus0.Mem_OE = 1'b0;
      rdExpQ.push_back(exp);
      for (int cyc = 0; cyc < nCyc; cyc++) begin
         @(posedge clk);
         if (cyc == 1) begin
            #1; bus0.Mem_CE = 1'b1; bus0.Mem_OE = 1'b1;
         end
         @(negedge clk);
         if (bus0.SRAM_OE_N === 1'b0) oeLow++;
         if (bus0.SRAM_CE_N === 1'b0) ceLow++;
         if ((bus0.Rd_valid === 1'b1) && (validCyc < 0)) validCyc = cyc;
         if (cyc == 0) addrSeen = bus0.SRAM_ADDR;
      end
   endtask

   task automatic doWrite0(input logic [15:0] addr, input logic [15:0] data, input logic withOe,
                           input int nCyc, output int weLow, output int oeLow, output int ceLow,
                           output int doneCyc);
      weLow = 0; oeLow = 0; ceLow = 0; doneCyc = -1;
      @(posedge clk); #1;
      bus0.MAR = addr; bus0.MDR_wdata = data;
      bus0.Mem_CE = 1'b0; bus0.Mem_WE = 1'b0; bus0.Mem_OE = !withOe;
      for (int cyc = 0; cyc < nCyc; cyc++) begin
         @(posedge clk);
         if (cyc == 1) begin
            #1; bus0.Mem_CE = 1'b1; bus0.Mem_WE = 1'b1; bus0.Mem_OE = 1'b1;
         end
         @(negedge clk);
         if (bus0.SRAM_WE_N === 1'b0) weLow++;
         if (bus0.SRAM_OE_N === 1'b0) oeLow++;
         if (bus0.SRAM_CE_N === 1'b0) ceLow++;
         if ((bus0.Wr_done === 1'b1) && (doneCyc < 0)) doneCyc = cyc;
      end
   endtask

   task automatic test_reset();
      #2;
      checkCount++;
      if ({bus0.SRAM_CE_N, bus0.SRAM_OE_N, bus0.SRAM_WE_N, bus0.SRAM_UB_N, bus0.SRAM_LB_N,
           bus0.SRAM_drive, bus0.Rd_valid, bus0.Wr_done, bus0.Busy, bus0.Err} !== 10'b11111_00000)
         $display("[TB] FAIL reset_ctrl0 got=%b exp=%b", {bus0.SRAM_CE_N, bus0.SRAM_OE_N, bus0.SRAM_WE_N,
                  bus0.SRAM_UB_N, bus0.SRAM_LB_N, bus0.SRAM_drive, bus0.Rd_valid, bus0.Wr_done,
                  bus0.Busy, bus0.Err}, 10'b11111_00000);
      else passCount++;
      checkCount++;
      if ({bus0.SRAM_ADDR, bus0.SRAM_wdata, bus0.Rd_data, bus0.Hex_out} !== 68'h0)
         $display("[TB] FAIL reset_data0 got=%h exp=0", {bus0.SRAM_ADDR, bus0.SRAM_wdata, bus0.Rd_data, bus0.Hex_out});
      else passCount++;
      checkCount++;
      if ({bus2.SRAM_CE_N, bus2.SRAM_WE_N, bus2.SRAM_drive, bus2.Busy, bus2.Err} !== 5'b11000)
         $display("[TB] FAIL reset_ctrl2 got=%b exp=%b", {bus2.SRAM_CE_N, bus2.SRAM_WE_N, bus2.SRAM_drive,
                  bus2.Busy, bus2.Err}, 5'b11000);
      else passCount++;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checkCount++;
      if (bus0.Busy !== 1'b0) $display("[TB] FAIL idle_after_reset got=%b exp=0", bus0.Busy);
      else passCount++;
   endtask

   task automatic test_read();
      int oeLow, ceLow, validCyc;
      logic [19:0] addrSeen;
      doRead0(16'h0010, 16'hBEEF, 6, oeLow, ceLow, validCyc, addrSeen);
      checkCount++;
      if (addrSeen !== 20'h00010) $display("[TB] FAIL read_addr got=%h exp=%h", addrSeen, 20'h00010);
      else passCount++;
      checkCount++;
      if (oeLow !== 2) $display("[TB] FAIL read_oe_cycles got=%0d exp=2", oeLow);
      else passCount++;
      checkCount++;
      if (validCyc !== 2) $display("[TB] FAIL read_valid_cycle got=%0d exp=2", validCyc);
      else passCount++;
      checkCount++;
      if (bus0.Busy !== 1'b0) $display("[TB] FAIL read_done_idle got=%b exp=0", bus0.Busy);
      else passCount++;
   endtask

   task automatic test_io();
      int oeLow, ceLow, validCyc, weLow, doneCyc;
      logic [19:0] addrSeen;
      bus0.Switches = 16'h00A5;
      doRead0(16'hFFFF, 16'h00A5, 6, oeLow, ceLow, validCyc, addrSeen);
      checkCount++;
      if ({ceLow, oeLow} !== {32'd0, 32'd0}) $display("[TB] FAIL io_read_strobes got ce=%0d oe=%0d exp=0", ceLow, oeLow);
      else passCount++;
      checkCount++;
      if (validCyc !== 2) $display("[TB] FAIL io_read_valid_cycle got=%0d exp=2", validCyc);
      else passCount++;
      doWrite0(16'hFFFF, 16'h0042, 1'b0, 6, weLow, oeLow, ceLow, doneCyc);
      checkCount++;
      if (bus0.Hex_out !== 16'h0042) $display("[TB] FAIL io_write_hex got=%h exp=%h", bus0.Hex_out, 16'h0042);
      else passCount++;
      checkCount++;
      if ({ceLow, weLow} !== {32'd0, 32'd0}) $display("[TB] FAIL io_write_strobes got ce=%0d we=%0d exp=0", ceLow, weLow);
      else passCount++;
      checkCount++;
      if (bus0.Err !== 1'b0) $display("[TB] FAIL err_before_conflict got=%b exp=0", bus0.Err);
      else passCount++;
   endtask

   task automatic test_conflict();
      int weLow, oeLow, ceLow, doneCyc;
      doWrite0(16'h0060, 16'h6060, 1'b1, 6, weLow, oeLow, ceLow, doneCyc);
      checkCount++;
      if ({weLow, oeLow, doneCyc} !== {32'd1, 32'd0, 32'd3})
         $display("[TB] FAIL conflict_write got we=%0d oe=%0d done=%0d exp we=1 oe=0 done=3", weLow, oeLow, doneCyc);
      else passCount++;
      checkCount++;
      if (mem0[8'h60] !== 16'h6060) $display("[TB] FAIL conflict_mem got=%h exp=%h", mem0[8'h60], 16'h6060);
      else passCount++;
      checkCount++;
      if (bus0.Err !== 1'b1) $display("[TB] FAIL conflict_err got=%b exp=1", bus0.Err);
      else passCount++;
   endtask

   task automatic test_back_to_back();
      int oeLow, ceLow, validCyc, weLow, doneCyc;
      logic [19:0] addrSeen;
      doRead0(16'h0040, 16'h5A5A, 3, oeLow, ceLow, validCyc, addrSeen);
      checkCount++;
      if (validCyc !== 2) $display("[TB] FAIL b2b_read_valid got=%0d exp=2", validCyc);
      else passCount++;
      doWrite0(16'h0041, 16'hC3C3, 1'b0, 6, weLow, oeLow, ceLow, doneCyc);
      checkCount++;
      if ({weLow, doneCyc} !== {32'd1, 32'd3})
         $display("[TB] FAIL b2b_write got we=%0d done=%0d exp we=1 done=3", weLow, doneCyc);
      else passCount++;
      doRead0(16'h0041, 16'hC3C3, 6, oeLow, ceLow, validCyc, addrSeen);
      checkCount++;
      if (bus0.Err !== 1'b1) $display("[TB] FAIL err_sticky got=%b exp=1", bus0.Err);
      else passCount++;
   endtask

   task automatic test_write_wait();
      int weLow = 0, doneCyc = -1, riseCyc = -1;
      logic seenLow = 1'b0, unstable = 1'b0;
      logic [15:0] firstWd = 16'h0;
      @(posedge clk); #1;
      bus2.MAR = 16'h0020; bus2.MDR_wdata = 16'h1234; bus2.Mem_CE = 1'b0; bus2.Mem_WE = 1'b0;
      for (int cyc = 0; cyc < 9; cyc++) begin
         @(posedge clk);
         if (cyc == 1) begin
            #1; bus2.Mem_CE = 1'b1; bus2.Mem_WE = 1'b1;
         end
         @(negedge clk);
         if (bus2.SRAM_WE_N === 1'b0) begin
            if (!seenLow) firstWd = bus2.SRAM_wdata;
            else if (bus2.SRAM_wdata !== firstWd) unstable = 1'b1;
            seenLow = 1'b1;
            weLow++;
         end else if (seenLow && (riseCyc < 0)) begin
            riseCyc = cyc;
         end
         if ((bus2.Wr_done === 1'b1) && (doneCyc < 0)) doneCyc = cyc;
      end
      checkCount++;
      if (weLow !== 3) $display("[TB] FAIL wait_we_cycles got=%0d exp=3", weLow);
      else passCount++;
      checkCount++;
      if ({riseCyc, doneCyc} !== {32'd4, 32'd5})
         $display("[TB] FAIL wait_done_timing got rise=%0d done=%0d exp rise=4 done=5", riseCyc, doneCyc);
      else passCount++;
      checkCount++;
      if ({unstable, firstWd} !== {1'b0, 16'h1234})
         $display("[TB] FAIL wait_wdata_stable got unstable=%b data=%h exp 0/%h", unstable, firstWd, 16'h1234);
      else passCount++;
      checkCount++;
      if (mem2[8'h20] !== 16'h1234) $display("[TB] FAIL wait_mem got=%h exp=%h", mem2[8'h20], 16'h1234);
      else passCount++;
   endtask

   task automatic test_reset_mid_write();
      @(posedge clk); #1;
      bus2.MAR = 16'h0050; bus2.MDR_wdata = 16'h7777; bus2.Mem_CE = 1'b0; bus2.Mem_WE = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (bus2.SRAM_WE_N !== 1'b0) $display("[TB] FAIL midwr_in_pulse got WE_N=%b exp=0", bus2.SRAM_WE_N);
      else passCount++;
      #1 rst_n = 1'b0;
      #1;
      checkCount++;
      if ({bus2.SRAM_WE_N, bus2.SRAM_CE_N, bus2.SRAM_drive, bus2.Busy} !== 4'b1100)
         $display("[TB] FAIL midwr_async got=%b exp=%b", {bus2.SRAM_WE_N, bus2.SRAM_CE_N, bus2.SRAM_drive,
                  bus2.Busy}, 4'b1100);
      else passCount++;
      checkCount++;
      if ({bus0.Hex_out, bus0.Err} !== 17'h0) $display("[TB] FAIL midwr_hex_err got hex=%h err=%b exp 0/0", bus0.Hex_out, bus0.Err);
      else passCount++;
      bus2.Mem_CE = 1'b1; bus2.Mem_WE = 1'b1;
      @(posedge clk); #3 rst_n = 1'b1;
      @(negedge clk);
      checkCount++;
      if (bus2.Busy !== 1'b0) $display("[TB] FAIL midwr_idle_after got=%b exp=0", bus2.Busy);
      else passCount++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem0[i] = 16'h0;
         mem2[i] = 16'h0;
      end
      mem0[8'h10] = 16'hBEEF;
      mem0[8'h40] = 16'h5A5A;
      bus0.Mem_CE = 1'b1; bus0.Mem_OE = 1'b1; bus0.Mem_WE = 1'b1;
      bus0.MAR = 16'h0; bus0.MDR_wdata = 16'h0; bus0.Switches = 16'h0;
      bus2.Mem_CE = 1'b1; bus2.Mem_OE = 1'b1; bus2.Mem_WE = 1'b1;
      bus2.MAR = 16'h0; bus2.MDR_wdata = 16'h0; bus2.Switches = 16'h0;
      $display("[TB] starting mem_access_seq bench");
      test_reset();
      test_read();
      test_io();
      test_conflict();
      test_back_to_back();
      test_write_wait();
      test_reset_mid_write();
      repeat (2) @(negedge clk);
      checkCount++;
      if (rdExpQ.size() != 0) $display("[TB] FAIL rd_outstanding got=%0d exp=0", rdExpQ.size());
      else passCount++;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
